// File: rtl/cheshire_regbus_arb.sv
`default_nettype none
// ============================================================================
// Module   : cheshire_regbus_arb
// Brief    : Round-robin arbiter sharing the Cheshire peripheral register bus
//            among NumReq requesters; one grant held per transaction.
// Options  : CHESHIRE_REGBUS_ARB_TIMEOUT_EN enables the response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cheshire_regbus_arb #(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     req_valid_i,
    input  logic [NumReq-1:0]                     req_write_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]      req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]      req_wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]    req_wstrb_i,
    output logic [NumReq-1:0]                     req_ready_o,
    output logic [DataWidth-1:0]                  req_rdata_o,
    output logic                                  req_error_o,
    output logic                                  dn_valid_o,
    output logic                                  dn_write_o,
    output logic [AddrWidth-1:0]                  dn_addr_o,
    output logic [DataWidth-1:0]                  dn_wdata_o,
    output logic [DataWidth/8-1:0]                dn_wstrb_o,
    input  logic                                  dn_ready_i,
    input  logic [DataWidth-1:0]                  dn_rdata_i,
    input  logic                                  dn_error_i,
    output logic                                  busy_o,
    output logic                                  timeout_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_param_check
        $error("cheshire_regbus_arb: parameter out of range");
    end

    typedef enum logic [1:0] {
`ifdef CHESHIRE_REGBUS_ARB_TIMEOUT_EN
        ST_ERR  = 2'd2,
`endif
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_t;

    state_t          state, state_next;
    logic [IdxW-1:0] gnt_idx, gnt_next;
    logic [IdxW-1:0] rr_ptr, rr_next;
    logic [IdxW-1:0] pick;
    logic            pick_found;
    logic [IdxW-1:0] gnt_succ;
    int              cand;

    // First valid requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= int'(NumReq)) begin
                cand = cand - int'(NumReq);
            end
            if (!pick_found && req_valid_i[cand[IdxW-1:0]]) begin
                pick_found = 1'b1;
                pick       = cand[IdxW-1:0];
            end
        end
    end

    assign gnt_succ = (int'(gnt_idx) + 1 >= int'(NumReq)) ? '0 : gnt_idx + IdxW'(1);

`ifdef CHESHIRE_REGBUS_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Counter holds the number of stalled BUSY cycles already elapsed, so the
    // watchdog fires on the TimeoutCycles+1-th cycle after dn_valid_o rises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else if (state == ST_BUSY && !dn_ready_i) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else if (state != ST_BUSY) begin
            wd_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_next;
            gnt_idx <= gnt_next;
            rr_ptr  <= rr_next;
        end
    end

    always_comb begin
        state_next  = state;
        gnt_next    = gnt_idx;
        rr_next     = rr_ptr;
        req_ready_o = '0;
        req_rdata_o = '0;
        req_error_o = 1'b0;
        dn_valid_o  = 1'b0;
        dn_write_o  = 1'b0;
        dn_addr_o   = '0;
        dn_wdata_o  = '0;
        dn_wstrb_o  = '0;
        busy_o      = 1'b0;
        timeout_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_next   = pick;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy_o     = 1'b1;
                dn_valid_o = req_valid_i[gnt_idx];
                dn_write_o = req_write_i[gnt_idx];
                dn_addr_o  = req_addr_i[gnt_idx];
                dn_wdata_o = req_wdata_i[gnt_idx];
                dn_wstrb_o = req_wstrb_i[gnt_idx];
                if (!req_valid_i[gnt_idx]) begin
                    // Requester abandoned the transfer: keep its turn.
                    state_next = ST_IDLE;
                end else if (dn_ready_i) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    req_rdata_o          = dn_rdata_i;
                    req_error_o          = dn_error_i;
                    rr_next              = gnt_succ;
                    state_next           = ST_IDLE;
                end
`ifdef CHESHIRE_REGBUS_ARB_TIMEOUT_EN
                else if (wd_cnt == 16'(TimeoutCycles)) begin
                    timeout_o  = 1'b1;
                    state_next = ST_ERR;
                end
`endif
            end
`ifdef CHESHIRE_REGBUS_ARB_TIMEOUT_EN
            ST_ERR: begin
                busy_o               = 1'b1;
                req_ready_o[gnt_idx] = 1'b1;
                req_error_o          = 1'b1;
                rr_next              = gnt_succ;
                state_next           = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cheshire_regbus_arb.sv
`default_nettype none
// Directed self-checking bench for cheshire_regbus_arb (3 requesters).
module tb_cheshire_regbus_arb;

    localparam int unsigned NumReq        = 3;
    localparam int unsigned AddrWidth     = 48;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned TimeoutCycles = 6;

    logic                               clk = 1'b0;
    logic                               rst;
    logic [NumReq-1:0]                  valid, write;
    logic [NumReq-1:0][AddrWidth-1:0]   addr;
    logic [NumReq-1:0][DataWidth-1:0]   wdata;
    logic [NumReq-1:0][DataWidth/8-1:0] wstrb;
    logic [NumReq-1:0]                  ready;
    logic [DataWidth-1:0]               rdata;
    logic                               error;
    logic                               dn_valid, dn_write;
    logic [AddrWidth-1:0]               dn_addr;
    logic [DataWidth-1:0]               dn_wdata;
    logic [DataWidth/8-1:0]             dn_wstrb;
    logic                               dn_ready;
    logic [DataWidth-1:0]               dn_rdata;
    logic                               dn_error;
    logic                               busy, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cheshire_regbus_arb #(
        .NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_write_i(write), .req_addr_i(addr),
        .req_wdata_i(wdata), .req_wstrb_i(wstrb),
        .req_ready_o(ready), .req_rdata_o(rdata), .req_error_o(error),
        .dn_valid_o(dn_valid), .dn_write_o(dn_write), .dn_addr_o(dn_addr),
        .dn_wdata_o(dn_wdata), .dn_wstrb_o(dn_wstrb),
        .dn_ready_i(dn_ready), .dn_rdata_i(dn_rdata), .dn_error_i(dn_error),
        .busy_o(busy), .timeout_o(timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dnv"}, 64'(dn_valid), 64'd0);
        check({tag, "_addr"}, 64'(dn_addr), 64'd0);
        check({tag, "_rdy"}, 64'(ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_to"}, 64'(timeout), 64'd0);
        check({tag, "_err"}, 64'(error), 64'd0);
        check({tag, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    int rot_exp [4] = '{1, 2, 0, 1};

    initial begin
        rst = 1'b1; valid = '0; write = '0; dn_ready = 1'b0; dn_rdata = '0; dn_error = 1'b0;
        addr[0] = 48'h0000_0200_0000; addr[1] = 48'h0000_0300_1000; addr[2] = 48'h0000_0C00_0004;
        wdata = '0; wstrb = '0;
        tick(); tick();
        rst = 1'b0; #1;
        check_all_zero("reset");

        // Single read from requester 0, zero-wait slave
        tick(); valid = 3'b001; dn_ready = 1'b1; dn_rdata = 32'hDEAD_BEEF; #1;
        check("rd_idle_dnv", 64'(dn_valid), 64'd0);
        tick(); #1;
        check("rd_dnv", 64'(dn_valid), 64'd1);
        check("rd_addr", 64'(dn_addr), 64'h0200_0000);
        check("rd_write", 64'(dn_write), 64'd0);
        check("rd_rdy", 64'(ready), 64'b001);
        check("rd_rdata", 64'(rdata), 64'hDEAD_BEEF);
        tick(); valid = '0; #1;
        check("rd_after_rdy", 64'(ready), 64'd0);
        check("rd_after_busy", 64'(busy), 64'd0);

        // All requesters valid: rotation starting at rr_ptr = 1
        tick(); valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rot_idle_rdy", 64'(ready), 64'd0);
            check("rot_idle_busy", 64'(busy), 64'd0);
            tick(); #1;
            check("rot_rdy", 64'(ready), 64'(3'b001 << rot_exp[k]));
            check("rot_addr", 64'(dn_addr), 64'(addr[rot_exp[k]]));
            tick();
        end
        valid = '0; dn_ready = 1'b0;

        // Write from requester 2, slave waits 5 cycles
        valid = 3'b100; write = 3'b100; wdata[2] = 32'h1234_5678; wstrb[2] = 4'b0011;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) dn_ready = 1'b1;
            #1;
            check("wr_dnv", 64'(dn_valid), 64'd1);
            check("wr_write", 64'(dn_write), 64'd1);
            check("wr_addr", 64'(dn_addr), 64'h0C00_0004);
            check("wr_wdata", 64'(dn_wdata), 64'h1234_5678);
            check("wr_wstrb", 64'(dn_wstrb), 64'b0011);
            check("wr_rdy", 64'(ready), (k == 5) ? 64'b100 : 64'd0);
            tick();
        end
        valid = '0; write = '0; dn_ready = 1'b0;

        // Silent slave: requester 1 granted (rr_ptr = 0, only 1 valid)
        valid = 3'b010; dn_rdata = 32'h55AA_55AA;
        tick();
`ifdef CHESHIRE_REGBUS_ARB_TIMEOUT_EN
        for (int k = 0; k <= int'(TimeoutCycles); k++) begin
            #1;
            check("to_pulse", 64'(timeout), (k == int'(TimeoutCycles)) ? 64'd1 : 64'd0);
            check("to_rdy", 64'(ready), 64'd0);
            check("to_dnv", 64'(dn_valid), 64'd1);
            tick();
        end
        #1;
        check("err_dnv", 64'(dn_valid), 64'd0);
        check("err_rdy", 64'(ready), 64'b010);
        check("err_flag", 64'(error), 64'd1);
        check("err_rdata", 64'(rdata), 64'd0);
        check("err_busy", 64'(busy), 64'd1);
        check("err_to", 64'(timeout), 64'd0);
        tick();
`else
        for (int k = 0; k < 1000; k++) begin
            #1;
            check("hold_rdy", 64'(ready), 64'd0);
            check("hold_dnv", 64'(dn_valid), 64'd1);
            check("hold_to", 64'(timeout), 64'd0);
            tick();
        end
        dn_ready = 1'b1; #1;
        check("hold_done_rdy", 64'(ready), 64'b010);
        tick();
`endif
        valid = '0; dn_ready = 1'b0; #1;
        check("to_idle_busy", 64'(busy), 64'd0);

        // Ready on the same cycle the watchdog limit is reached: rr_ptr = 2
        valid = 3'b100; dn_rdata = 32'hCAFE_F00D;
        tick();
        for (int k = 0; k <= int'(TimeoutCycles); k++) begin
            if (k == int'(TimeoutCycles)) dn_ready = 1'b1;
            #1;
            check("race_rdy", 64'(ready), (k == int'(TimeoutCycles)) ? 64'b100 : 64'd0);
            check("race_to", 64'(timeout), 64'd0);
            tick();
        end
        valid = '0; dn_ready = 1'b0;
        check("race_rdata_prev", 64'(rdata), 64'd0);

        // Reset during BUSY with requester 1 still valid (rr_ptr = 0)
        valid = 3'b010;
        tick(); #1;
        check("rst_pre_dnv", 64'(dn_valid), 64'd1);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check_all_zero("rst_post");
        tick(); #1;
        check("rst_regrant_dnv", 64'(dn_valid), 64'd1);
        check("rst_regrant_addr", 64'(dn_addr), 64'(addr[1]));
        dn_ready = 1'b1; #1;
        check("rst_regrant_rdy", 64'(ready), 64'b010);
        tick(); valid = '0; dn_ready = 1'b0;

        // Protocol violation: granted requester 2 drops valid, keeps its turn
        valid = 3'b110;
        tick(); #1;
        check("viol_addr", 64'(dn_addr), 64'(addr[2]));
        valid = 3'b010; #1;
        check("viol_dnv", 64'(dn_valid), 64'd0);
        check("viol_rdy", 64'(ready), 64'd0);
        tick(); valid = 3'b111; #1;
        check("viol_idle", 64'(busy), 64'd0);
        tick(); dn_ready = 1'b1; #1;
        check("viol_regrant_addr", 64'(dn_addr), 64'(addr[2]));
        check("viol_regrant_rdy", 64'(ready), 64'b100);
        tick(); valid = '0; dn_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
